instruction_fetcher: RTL and testbench

- Producer end of the fetch→decode interface of the out-of-order RV32I core.
- Fetches 32-bit instruction words from the memory controller, buffers them with their PCs in a small in-order queue, and presents them to the decoder under a valid/ready handshake.
- Flushes and redirects on a pipeline `clear` from the ROB.

---
 rtl/instruction_fetcher.sv | 148 ++++++++++++++
 tb/tb_instruction_fetcher.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetcher.sv
// rtl/instruction_fetcher.sv - RV32I fetch stage with in-order instruction queue
//
// Issues one 32-bit fetch at a time to the memory controller, buffers returned
// words with their PCs in a 2**IQ_WIDTH entry queue and presents the queue head
// to the decoder under a valid/ready handshake. A ROB clear empties the queue,
// redirects the PC and causes any in-flight response to be dropped.
//
// Optional feature macro: JAL_PREDECODE_EN
//   defined   - a fetched JAL redirects the next fetch to its target
//   undefined - next fetch is always the fetched address + 4
//
// Ports:
//   clk_in, rst_in          clock, asynchronous active-low reset
//   rdy_in                  global enable, 0 freezes all state
//   clear, clear_pc         flush request and redirect target
//   mem_req, mem_addr       registered fetch request to memory
//   mem_valid, mem_data     one-cycle response pulse and instruction word
//   to_dec_valid/pc/inst    queue head presented to the decoder
//   dec_ready               decoder accepts the head this cycle

module instruction_fetcher #(
    parameter int          IQ_WIDTH = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic [31:0] clear_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data,
    output logic        to_dec_valid,
    output logic [31:0] to_dec_pc,
    output logic [31:0] to_dec_inst,
    input  logic        dec_ready
);

    localparam int                IQ_DEPTH = 2 ** IQ_WIDTH;
    localparam logic [IQ_WIDTH:0] CNT_FULL = (IQ_WIDTH + 1)'(IQ_DEPTH);
    localparam logic [IQ_WIDTH:0] CNT_ONE  = (IQ_WIDTH + 1)'(1);
    localparam logic [IQ_WIDTH-1:0] PTR_ONE = IQ_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t              state;
    logic [31:0]         pc;
    logic [IQ_WIDTH-1:0] head;
    logic [IQ_WIDTH-1:0] tail;
    logic [IQ_WIDTH:0]   count;
    logic [31:0]         pc_mem   [IQ_DEPTH];
    logic [31:0]         inst_mem [IQ_DEPTH];

    logic        push;
    logic        pop;
    logic [31:0] next_pc;

    // A clear on the same edge cancels both queue operations.
    assign push = rdy_in && (state == S_WAIT) && mem_valid && !clear;
    assign pop  = rdy_in && to_dec_valid && dec_ready && !clear;

    assign to_dec_valid = (count != '0);
    assign to_dec_pc    = pc_mem[head];
    assign to_dec_inst  = inst_mem[head];

    always_comb begin
        next_pc = mem_addr + 32'd4;
`ifdef JAL_PREDECODE_EN
        // JAL target: mem_addr + sign-extended J-immediate.
        if (mem_data[6:0] == 7'b1101111) begin
            next_pc = mem_addr + {{11{mem_data[31]}}, mem_data[31], mem_data[19:12],
                                  mem_data[20], mem_data[30:21], 1'b0};
        end
`endif
    end

    // Queue storage needs no reset: entries are only read when count says so.
    always_ff @(posedge clk_in) begin
        if (push) begin
            pc_mem[tail]   <= mem_addr;
            inst_mem[tail] <= mem_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            mem_req  <= 1'b0;
            mem_addr <= 32'h0;
        end else if (rdy_in) begin
            // Queue bookkeeping.
            if (clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PTR_ONE;
                if (pop)  head <= head + PTR_ONE;
                if (push && !pop)      count <= count + CNT_ONE;
                else if (pop && !push) count <= count - CNT_ONE;
            end

            // PC: a redirect always wins over the sequential/predicted next PC.
            if (clear)     pc <= clear_pc;
            else if (push) pc <= next_pc;

            case (state)
                S_IDLE: begin
                    // Issue only with a free slot, so the response always fits.
                    if (!clear && (count != CNT_FULL)) begin
                        state    <= S_WAIT;
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                    end
                end
                S_WAIT: begin
                    if (mem_valid) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                    end else if (clear) begin
                        // Request stays outstanding; its response must be dropped.
                        state <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (mem_valid) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetcher.sv
// tb/tb_instruction_fetcher.sv - self-checking bench for instruction_fetcher

module tb_instruction_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic [31:0] clear_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        to_dec_valid;
    logic [31:0] to_dec_pc;
    logic [31:0] to_dec_inst;
    logic        dec_ready;

    always #5 clk_in = ~clk_in;

    instruction_fetcher #(.IQ_WIDTH(2), .RESET_PC(32'h0)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .clear       (clear),
        .clear_pc    (clear_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_data    (mem_data),
        .to_dec_valid(to_dec_valid),
        .to_dec_pc   (to_dec_pc),
        .to_dec_inst (to_dec_inst),
        .dec_ready   (dec_ready)
    );

`ifdef JAL_PREDECODE_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: transaction-level view of the fetcher.
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    bit          m_pending;   // a request is outstanding
    bit          m_drop;      // its response must be thrown away
    logic [63:0] m_q[$];      // {pc, inst}, front = head

    // Memory responder state.
    bit busy;
    int cnt;
    int lat;
    bit rand_lat;
    int data_mode;
    bit jal_mode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_next_pc(input logic [31:0] a, input logic [31:0] w);
        int imm;
        bit is_jal;
        is_jal = (w[6:0] == 7'b1101111);
        imm = (w[31] ? -(1 << 20) : 0) + (int'(w[19:12]) << 12) + (int'(w[20]) << 11)
              + (int'(w[30:21]) << 1);
        if (JAL_EN && is_jal) return a + imm;
        return a + 32'd4;
    endfunction

    function automatic logic [31:0] make_word(input logic [31:0] a);
        logic [31:0] r;
        if (jal_mode && a == 32'h20) return 32'h0080006F;
        if (data_mode == 0) return 32'h00000013;
        r = $urandom;
        r[6:0] = 7'b0010011;
        return r;
    endfunction

    task automatic model_reset();
        m_pc      = 32'h0;
        m_addr    = 32'h0;
        m_pending = 1'b0;
        m_drop    = 1'b0;
        m_q.delete();
    endtask

    task automatic model_step();
        int sz;
        bit do_pop;
        if (!rst_in) begin
            model_reset();
            return;
        end
        if (!rdy_in) return;
        sz = m_q.size();
        do_pop = (sz != 0) && dec_ready;
        if (clear) begin
            m_q.delete();
            m_pc = clear_pc;
            if (m_pending) begin
                if (mem_valid) begin
                    m_pending = 1'b0;
                    m_drop    = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
            end
        end else begin
            if (do_pop) void'(m_q.pop_front());
            if (m_pending) begin
                if (mem_valid) begin
                    if (!m_drop) begin
                        m_q.push_back({m_addr, mem_data});
                        m_pc = ref_next_pc(m_addr, mem_data);
                    end
                    m_pending = 1'b0;
                    m_drop    = 1'b0;
                end
            end else if (sz < 4) begin
                m_pending = 1'b1;
                m_addr    = m_pc;
            end
        end
    endtask

    task automatic compare_all();
        logic [63:0] h;
        chk("mem_req", mem_req, m_pending);
        chk("mem_addr", mem_addr, m_addr);
        chk("to_dec_valid", to_dec_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            h = m_q[0];
            chk("to_dec_pc", to_dec_pc, h[63:32]);
            chk("to_dec_inst", to_dec_inst, h[31:0]);
        end
    endtask

    // One clock: drive memory response at the falling edge, advance the model,
    // then check the DUT one time unit after the rising edge.
    task automatic cycle();
        @(negedge clk_in);
        mem_valid = 1'b0;
        if (!busy && mem_req) begin
            busy = 1'b1;
            cnt  = rand_lat ? $urandom_range(0, 3) : lat;
        end
        if (busy) begin
            if (cnt == 0) begin
                mem_valid = 1'b1;
                mem_data  = make_word(mem_addr);
                busy      = 1'b0;
            end else begin
                cnt--;
            end
        end
        model_step();
        @(posedge clk_in);
        #1;
        compare_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        bit seen20;
        rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; clear_pc = 32'h0;
        dec_ready = 1'b0; mem_valid = 1'b0; mem_data = 32'h0;
        busy = 1'b0; cnt = 0; lat = 2; rand_lat = 1'b0; data_mode = 0; jal_mode = 1'b0;
        model_reset();
        #1;
        chk("reset_req", mem_req, 1'b0);
        chk("reset_valid", to_dec_valid, 1'b0);
        chk("reset_addr", mem_addr, 32'h0);
        cycle();
        cycle();

        // Release reset: first edge issues at RESET_PC.
        rst_in = 1'b1;
        cycle();
        chk("issue_req", mem_req, 1'b1);
        chk("issue_addr", mem_addr, 32'h0);

        // Fill with the decoder stalled.
        repeat (30) cycle();
        chk("fill_req", mem_req, 1'b0);
        chk("fill_valid", to_dec_valid, 1'b1);
        chk("fill_pc", to_dec_pc, 32'h0);

        // Drain on consecutive cycles.
        dec_ready = 1'b1;
        cycle(); chk("drain_pc1", to_dec_pc, 32'h4);
        cycle(); chk("drain_pc2", to_dec_pc, 32'h8);
        cycle(); chk("drain_pc3", to_dec_pc, 32'hC);
        chk("drain_next_addr", mem_addr, 32'h10);

        // Flush while a response is pending.
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_req && !busy) found = 1'b1;
            else cycle();
        end
        chk("flush_sync", found, 1'b1);
        clear = 1'b1; clear_pc = 32'h100;
        cycle();
        clear = 1'b0;
        chk("flush_valid", to_dec_valid, 1'b0);
        chk("flush_req_held", mem_req, 1'b1);
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (mem_req && mem_addr == 32'h100) break;
        end
        chk("redirect_addr", mem_addr, 32'h100);
        chk("redirect_empty", to_dec_valid, 1'b0);

        // JAL at 0x20.
        jal_mode = 1'b1; lat = 1;
        clear = 1'b1; clear_pc = 32'h20;
        cycle();
        clear = 1'b0;
        seen20 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (mem_req && mem_addr == 32'h20) seen20 = 1'b1;
            if (seen20 && mem_req && mem_addr != 32'h20) break;
        end
        chk("jal_next_addr", mem_addr, JAL_EN ? 32'h28 : 32'h24);
        jal_mode = 1'b0;

        // Stall during WAIT while the memory pulses.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_req && !busy) found = 1'b1;
            else cycle();
        end
        chk("stall_sync", found, 1'b1);
        rdy_in = 1'b0;
        repeat (5) begin
            cycle();
            chk("stall_req", mem_req, 1'b1);
        end
        rdy_in = 1'b1;
        repeat (10) cycle();

        // Randomized traffic.
        rand_lat = 1'b1; data_mode = 1;
        for (int i = 0; i < 600; i++) begin
            rdy_in    = ($urandom_range(0, 7) != 0);
            clear     = ($urandom_range(0, 15) == 0);
            clear_pc  = $urandom & 32'hFFFF_FFFC;
            dec_ready = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                             : ($urandom_range(0, 3) == 0);
            cycle();
        end
        clear = 1'b0; rdy_in = 1'b1; dec_ready = 1'b0;

        // Asynchronous reset in the middle of WAIT.
        repeat (12) cycle();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_req) found = 1'b1;
            else cycle();
        end
        chk("rst_sync", found, 1'b1);
        rst_in = 1'b0;
        #1;
        chk("rst_async_req", mem_req, 1'b0);
        chk("rst_async_valid", to_dec_valid, 1'b0);
        chk("rst_async_addr", mem_addr, 32'h0);
        model_reset();
        busy = 1'b0;
        cycle();
        cycle();
        rst_in = 1'b1;
        cycle();
        chk("rst_issue_req", mem_req, 1'b1);
        chk("rst_issue_addr", mem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
